// File: rtl/piso_serializer_ctrl.sv
// Parallel-in/serial-out sequencing controller: one-word holding buffer ahead of
// an MSB-first shifter paced by bit_en, with first/last framing and optional idle gap.
module piso_serializer_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             bit_en,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int              BW        = $clog2(WIDTH);
  localparam logic [BW-1:0]   BCNT_LAST = BW'(WIDTH - 1);
  localparam logic [7:0]      GCNT_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             accept;
  logic             load;

  assign in_ready = ~hold_valid_q;
  assign accept   = in_valid & in_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_valid_q) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_en) begin
          if (bcnt_q != BCNT_LAST) begin
            sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
            bcnt_d = bcnt_q + BW'(1);
          end else if (GAP > 0) begin
            gcnt_d  = 8'd0;
            state_d = ST_GAP;
          end else if (hold_valid_q) begin
            load = 1'b1;  // back-to-back word: next bit follows with no dead cycle
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (bit_en) begin
          if (gcnt_q == GCNT_LAST) begin
            if (hold_valid_q) begin
              load    = 1'b1;
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            gcnt_d = gcnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      sreg_d = hold_data_q;
      bcnt_d = '0;
    end
  end

  // A draining hold never accepts on the same edge: accept needs hold_valid_q=0, load needs 1.
  assign hold_valid_d = load ? 1'b0 : (accept ? 1'b1 : hold_valid_q);
  assign hold_data_d  = accept ? in_data : hold_data_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hold_valid_q <= 1'b0;
      sreg_q       <= '0;
      bcnt_q       <= '0;
      gcnt_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      sreg_q       <= sreg_d;
      bcnt_q       <= bcnt_d;
      gcnt_q       <= gcnt_d;
    end
  end

  // NOTE: hold_data is left unreset; it is only ever consumed while hold_valid_q is set.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
  end

  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_data  = ser_valid & sreg_q[WIDTH-1];
  assign ser_first = ser_valid & (bcnt_q == '0);
  assign ser_last  = ser_valid & (bcnt_q == BCNT_LAST);
  assign busy      = (state_q != ST_IDLE) | hold_valid_q;

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Bench for piso_serializer_ctrl: three instances (W4/G0, W4/G2, W8/G0), directed
// timing steps plus randomized traffic checked against a bit-queue reference model.
module tb_piso_serializer_ctrl;

  localparam int NI = 3;

  typedef struct packed {
    logic d;
    logic f;
    logic l;
  } exp_bit_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [NI];
  logic       bit_en    [NI];
  logic [7:0] in_data   [NI];
  logic       in_ready  [NI];
  logic       ser_data  [NI];
  logic       ser_valid [NI];
  logic       ser_first [NI];
  logic       ser_last  [NI];
  logic       busy      [NI];

  int widths [NI] = '{4, 4, 8};
  int act;
  bit sb_on;
  int vectors;
  int miscompares;
  exp_bit_t expq [$];

  always #5 clk = ~clk;

  piso_serializer_ctrl #(.WIDTH(4), .GAP(0)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][3:0]), .bit_en(bit_en[0]), .ser_data(ser_data[0]),
    .ser_valid(ser_valid[0]), .ser_first(ser_first[0]), .ser_last(ser_last[0]),
    .busy(busy[0])
  );

  piso_serializer_ctrl #(.WIDTH(4), .GAP(2)) u_w4_gap (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][3:0]), .bit_en(bit_en[1]), .ser_data(ser_data[1]),
    .ser_valid(ser_valid[1]), .ser_first(ser_first[1]), .ser_last(ser_last[1]),
    .busy(busy[1])
  );

  piso_serializer_ctrl #(.WIDTH(8), .GAP(0)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .bit_en(bit_en[2]), .ser_data(ser_data[2]),
    .ser_valid(ser_valid[2]), .ser_first(ser_first[2]), .ser_last(ser_last[2]),
    .busy(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock edge. The model sees the handshake and bit consumption as they stood
  // before the edge, then the active instance's outputs are compared after it.
  task automatic tick();
    bit         acc;
    bit         adv;
    bit         r;
    logic [7:0] w;
    acc = (in_valid[act] === 1'b1) && (in_ready[act] === 1'b1);
    adv = (ser_valid[act] === 1'b1) && (bit_en[act] === 1'b1);
    r   = (rst === 1'b1);
    w   = in_data[act];
    @(posedge clk);
    #1;
    if (r) begin
      expq.delete();
    end else begin
      if (adv && expq.size() > 0) void'(expq.pop_front());
      if (acc)
        for (int b = widths[act] - 1; b >= 0; b--)
          expq.push_back('{d: w[b], f: (b == widths[act] - 1), l: (b == 0)});
    end
    if (sb_on) begin
      if (ser_valid[act] === 1'b1) begin
        if (expq.size() == 0) begin
          check("sb_unexpected_bit", 1, 0);
        end else begin
          check("sb_data",  ser_data[act],  expq[0].d);
          check("sb_first", ser_first[act], expq[0].f);
          check("sb_last",  ser_last[act],  expq[0].l);
        end
      end else begin
        check("sb_idle_outputs", {ser_valid[act], ser_data[act], ser_first[act], ser_last[act]}, 0);
      end
    end
  endtask

  initial begin
    logic [3:0]  pat4;
    logic [7:0]  pat8;
    logic [7:0]  irdy8;
    logic [10:0] vexp;
    logic [10:0] irdy11;
    int          nvalid;

    vectors     = 0;
    miscompares = 0;
    sb_on       = 1'b0;
    act         = 0;
    rst         = 1'b1;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = 8'h00;
      bit_en[k]   = 1'b0;
    end

    // Reset state
    tick();
    tick();
    for (int k = 0; k < NI; k++) begin
      check("reset_in_ready",  in_ready[k],  1);
      check("reset_busy",      busy[k],      0);
      check("reset_ser_valid", ser_valid[k], 0);
      check("reset_ser_flags", {ser_data[k], ser_first[k], ser_last[k]}, 0);
    end
    rst   = 1'b0;
    sb_on = 1'b1;
    tick();

    // Single word 1011, GAP=0, bit_en high
    act = 0;
    pat4 = 4'b1011;
    in_valid[0] = 1'b1; in_data[0] = 8'h0B; bit_en[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    check("t1_busy_c0",  busy[0],      1);
    check("t1_valid_c0", ser_valid[0], 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("t1_valid", ser_valid[0], 1);
      check("t1_data",  ser_data[0],  pat4[4-c]);
      check("t1_first", ser_first[0], (c == 1));
      check("t1_last",  ser_last[0],  (c == 4));
    end
    tick();
    check("t1_done_valid", ser_valid[0], 0);
    check("t1_done_busy",  busy[0],      0);
    check("t1_done_ready", in_ready[0],  1);

    // Back-to-back A then 5: 8 contiguous bits, in_ready low while hold is full
    pat8  = 8'b1010_0101;
    irdy8 = 8'b1111_0001;
    in_valid[0] = 1'b1; in_data[0] = 8'h0A;
    tick();
    check("t2_ready_c0", in_ready[0], 0);
    in_data[0] = 8'h05;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) in_valid[0] = 1'b0;
      check("t2_valid", ser_valid[0], 1);
      check("t2_data",  ser_data[0],  pat8[8-c]);
      check("t2_ready", in_ready[0],  irdy8[c-1]);
    end
    tick();
    check("t2_done_valid", ser_valid[0], 0);

    // Pacing: bit_en alternating, word 1100, each bit held two cycles
    in_valid[0] = 1'b1; in_data[0] = 8'h0C; bit_en[0] = 1'b0;
    tick();
    in_valid[0] = 1'b0;
    nvalid = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      nvalid += int'(ser_valid[0]);
      check("t3_valid", ser_valid[0], (c <= 8));
      if (c <= 8) begin
        check("t3_data",  ser_data[0],  (c <= 4));
        check("t3_first", ser_first[0], (c <= 2));
        check("t3_last",  ser_last[0],  (c >= 7));
      end
      bit_en[0] = (c % 2 == 0);
    end
    check("t3_valid_count", nvalid, 8);
    bit_en[0] = 1'b1;

    // GAP=2 instance: two idle cycles between words
    act = 1;
    vexp = 11'b0_1111_00_1111;
    in_valid[1] = 1'b1; in_data[1] = 8'h09; bit_en[1] = 1'b1;
    tick();
    in_data[1] = 8'h06;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 2) in_valid[1] = 1'b0;
      check("t4_valid", ser_valid[1], vexp[c-1]);
      if (c == 4) check("t4_last_w1",  ser_last[1],  1);
      if (c == 7) check("t4_first_w2", ser_first[1], 1);
    end
    check("t4_drained", expq.size(), 0);

    // Reset during the third bit with a second word held
    act = 0;
    in_valid[0] = 1'b1; in_data[0] = 8'h0D; bit_en[0] = 1'b1;
    tick();
    in_data[0] = 8'h07;
    tick();
    tick();
    in_valid[0] = 1'b0;
    tick();
    check("t5_third_bit_valid", ser_valid[0], 1);
    check("t5_hold_full",       in_ready[0],  0);
    rst = 1'b1;
    tick();
    check("t5_rst_valid", ser_valid[0], 0);
    check("t5_rst_busy",  busy[0],      0);
    check("t5_rst_ready", in_ready[0],  1);
    rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      nvalid += int'(ser_valid[0]);
    end
    check("t5_no_residual_bits", nvalid, 0);

    // Backpressure on WIDTH=8: C3, 81, FF offered back-to-back
    act = 2;
    irdy11 = 11'b010_0000_0010;
    check("t6_ready_reset", in_ready[2], 1);
    in_valid[2] = 1'b1; in_data[2] = 8'hC3; bit_en[2] = 1'b1;
    tick();
    check("t6_ready", in_ready[2], irdy11[0]);
    in_data[2] = 8'h81;
    nvalid = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (c == 2)  in_data[2]  = 8'hFF;
      if (c == 10) in_valid[2] = 1'b0;
      if (c <= 10) check("t6_ready", in_ready[2], irdy11[c]);
      check("t6_valid", ser_valid[2], (c <= 24));
      nvalid += int'(ser_valid[2]);
    end
    check("t6_bit_count", nvalid, 24);
    check("t6_drained",   expq.size(), 0);

    // Randomized traffic on each instance against the bit-queue model
    for (int k = 0; k < NI; k++) begin
      act = k;
      for (int c = 0; c < 400; c++) begin
        if (!(in_valid[k] && !in_ready[k])) begin
          in_valid[k] = ($urandom_range(0, 3) != 0);
          in_data[k]  = 8'($urandom);
        end
        bit_en[k] = ($urandom_range(0, 9) < 7);
        tick();
      end
      in_valid[k] = 1'b0;
      bit_en[k]   = 1'b1;
      for (int i = 0; i < 400; i++) begin
        if (expq.size() == 0 && busy[k] === 1'b0) break;
        tick();
      end
      check("rand_drained", expq.size(), 0);
      check("rand_idle",    busy[k],     0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_serializer_ctrl.md
Name: piso_serializer_ctrl

Overview:
- Sequencing controller for a parallel-in/serial-out shift datapath.
- Accepts parallel words on a valid/ready interface and buffers one word ahead of the shifter.
- Shifts each word out MSB-first, paced by a bit-enable strobe, with first/last framing flags and an optional idle gap between words.
- Sits between a word producer (FIFO, register block) and a serial line driver.

Parameters:
- WIDTH, 4, bits per word; legal range 2..32.
- GAP, 0, bit-enable-qualified idle cycles inserted between consecutive words; legal range 0..255.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  parallel word.
- bit_en  input  1  bit-rate strobe; shifting and gap counting advance only on edges where this is 1.
- ser_data  output  1  serial bit; MSB of the shift register.
- ser_valid  output  1  ser_data carries a word bit.
- ser_first  output  1  current bit is bit WIDTH-1 of the word (first bit out).
- ser_last  output  1  current bit is bit 0 of the word (last bit out).
- busy  output  1  state is not IDLE, or the holding register is full.

Behaviour:
- Storage:
  - Holding register hold_data/hold_valid.
  - Shift register sreg[WIDTH-1:0].
  - Bit counter bcnt, clog2(WIDTH) bits.
  - Gap counter gcnt, 8 bits.
  - States: IDLE, SHIFT, GAP.
- Reset (rst=1 at an edge), values after that edge:
  - state=IDLE, hold_valid=0, sreg=0, bcnt=0, gcnt=0.
  - Outputs: ser_data=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, in_ready=1.
  - rst takes priority over all other activity. A word partly shifted or held is discarded, with no further ser_valid.
- Input handshake:
  - in_ready = ~hold_valid (combinational, registered source).
  - A transfer occurs at an edge where in_valid & in_ready; hold_data<=in_data, hold_valid<=1.
  - No same-edge refill: a hold being drained at an edge cannot accept at that edge.
  - The producer must keep in_data stable while in_valid=1 and in_ready=0.
- IDLE:
  - If hold_valid: sreg<=hold_data, hold_valid<=0, bcnt<=0, go SHIFT. This step does not require bit_en.
  - Latency: word accepted at edge N is loaded at edge N+1. The first bit is visible from N+1 until the next bit_en edge.
- SHIFT:
  - ser_valid=1, ser_data=sreg[WIDTH-1], ser_first=(bcnt==0), ser_last=(bcnt==WIDTH-1).
  - bit_en=1 and bcnt<WIDTH-1: sreg<=sreg<<1 (LSB fill 0), bcnt<=bcnt+1.
  - bit_en=1 and bcnt==WIDTH-1 (word complete), in priority order:
    - If GAP>0: gcnt<=0, go GAP.
    - Else if hold_valid: load next word as in IDLE and stay SHIFT. This gives a seamless next bit with no dead cycle.
    - Else: go IDLE.
  - bit_en=0: hold all state; outputs unchanged.
- GAP:
  - ser_valid=0, ser_data=0, flags 0.
  - On each bit_en=1 edge, gcnt<=gcnt+1.
  - At gcnt==GAP-1 with bit_en: if hold_valid, load and go SHIFT; else go IDLE.
- ser_data, ser_first and ser_last are 0 whenever ser_valid=0.
- Throughput with GAP=0 and bit_en tied high: one bit per cycle, continuous across words when the producer keeps the hold full.

Test Plan:
- Single word, WIDTH=4, GAP=0, bit_en=1, in_data=4'b1011 accepted at edge 0:
  - ser_valid=1 over cycles 1..4 with ser_data 1,0,1,1.
  - ser_first only in cycle 1, ser_last only in cycle 4.
  - IDLE with busy=0 from cycle 5.
- Back-to-back, in_valid held high with 4'hA then 4'h5:
  - 8 contiguous ser_valid bits 1,0,1,0,0,1,0,1; no dead cycle between words.
  - in_ready=0 while the hold is full.
- Pacing with bit_en toggling 1,0,1,0 and word 4'b1100:
  - Each bit is held for 2 cycles.
  - ser_first spans 2 cycles; total 8 valid cycles.
- GAP=2 instance, two words queued, bit_en=1:
  - Exactly 2 cycles with ser_valid=0 between bit 0 of word 1 and bit WIDTH-1 of word 2.
- Reset mid-word during the third bit, with a second word held:
  - After the rst edge: ser_valid=0, busy=0, in_ready=1.
  - After release, no remaining bits of either word appear.
- Backpressure, WIDTH=8, GAP=0, three words 8'hC3, 8'h81, 8'hFF offered back-to-back:
  - in_ready pattern: 1 at reset, then 0 for one cycle, then 1 for one cycle, then 0 until the next hold drain.
  - All 24 bits are emitted in order, with no drop or duplication.
